// File: rtl/replay_issuer_pkg.sv
// Shared types and defaults for the replay issuer.
// Holds FSM encoding and the backoff load rule.
package replay_issuer_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_MAX_RETRY = 7;
  localparam int BO_W          = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    BACKOFF = 2'd2
  } state_t;

  // Exponential backoff, saturating at 2^3 - 1.
  function automatic logic [BO_W-1:0] backoff_load(
    input int unsigned retry
  );
    logic [BO_W-1:0] v;
    if (retry >= 3)
      v = 3'd7;
    else
      v = BO_W'((1 << retry) - 1);
    return v;
  endfunction

endpackage

// File: rtl/replay_fifo.sv
// Pending-request FIFO for the replay issuer.
// Power-of-2 depth; pointers wrap naturally.
module replay_fifo
  import replay_issuer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    hd;
  logic [PW-1:0]    tl;
  logic             do_enq;
  logic             do_deq;

  assign full   = count == CW'(DEPTH);
  assign empty  = count == '0;
  assign do_enq = enq && !full;
  assign do_deq = deq && !empty;
  assign head   = mem[hd];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
    end else begin
      if (do_enq)
        tl <= tl + PW'(1);
      if (do_deq)
        hd <= hd + PW'(1);
      count <= count + CW'(do_enq) - CW'(do_deq);
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq)
      mem[tl] <= enq_data;
  end

endmodule

// File: rtl/replay_issuer.sv
// Issues queued requests, re-issuing on replay with
// exponential backoff and dropping after MAX_RETRY.
module replay_issuer
  import replay_issuer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_enq_valid,
  output logic             io_enq_ready,
  input  logic [WIDTH-1:0] io_enq_bits,
  output logic             io_valid,
  output logic [WIDTH-1:0] io_bits,
  input  logic             io_replay,
  output logic             io_done,
  output logic             io_err,
  output logic [WIDTH-1:0] io_tag
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(MAX_RETRY + 1);

  state_t          state;
  state_t          nxt;
  logic [RW-1:0]   retry;
  logic [BO_W-1:0] bo;
  logic [WIDTH-1:0] tag_q;
  logic [WIDTH-1:0] head;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            enq;
  logic            issue;
  logic            at_max;
  logic            pop;
  logic            more;

  assign io_enq_ready = !full;
  assign enq    = io_enq_valid && io_enq_ready;
  assign issue  = state == ISSUE;
  assign at_max = retry == RW'(MAX_RETRY);
  assign pop    = issue && (!io_replay || at_max);
  // Occupancy after this cycle's pop, including a same-cycle enqueue.
  assign more   = (count > CW'(1)) || enq;

  replay_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .enq     (enq),
    .enq_data(io_enq_bits),
    .deq     (pop),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .head    (head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (!empty || enq)
          nxt = ISSUE;
      end
      ISSUE: begin
        if (pop)
          nxt = more ? ISSUE : IDLE;
        else
          nxt = BACKOFF;
      end
      BACKOFF: begin
        if (bo == '0)
          nxt = ISSUE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    io_valid = 1'b0;
    io_bits  = '0;
    io_done  = 1'b0;
    io_err   = 1'b0;
    io_tag   = tag_q;
    if (issue) begin
      io_valid = 1'b1;
      io_bits  = head;
      io_done  = !io_replay;
      io_err   = io_replay && at_max;
      if (pop)
        io_tag = head;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retry <= '0;
      bo    <= '0;
      tag_q <= '0;
    end else begin
      if (pop) begin
        retry <= '0;
        tag_q <= head;
      end else if (issue && io_replay) begin
        retry <= retry + RW'(1);
        bo    <= backoff_load(32'(retry));
      end else if (state == BACKOFF && bo != '0) begin
        bo <= bo - BO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_replay_issuer.sv
// Self-checking bench for replay_issuer: directed
// scenarios plus randomized traffic against a queue model.
module tb_replay_issuer;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int MR = 7;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         io_enq_valid = 1'b0;
  logic         io_enq_ready;
  logic [W-1:0] io_enq_bits = '0;
  logic         io_valid;
  logic [W-1:0] io_bits;
  logic         io_replay = 1'b0;
  logic         io_done;
  logic         io_err;
  logic [W-1:0] io_tag;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  replay_issuer #(
    .WIDTH(W),
    .DEPTH(D),
    .MAX_RETRY(MR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .io_enq_valid(io_enq_valid),
    .io_enq_ready(io_enq_ready),
    .io_enq_bits (io_enq_bits),
    .io_valid    (io_valid),
    .io_bits     (io_bits),
    .io_replay   (io_replay),
    .io_done     (io_done),
    .io_err      (io_err),
    .io_tag      (io_tag)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    io_enq_valid = 1'b0;
    io_enq_bits  = '0;
    io_replay    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) next_cycle();
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #2;
    total++;
    if ({io_valid, io_done, io_err, io_enq_ready} !== 4'b0001)
      $display("FAIL reset_ctl got %b want 0001",
               {io_valid, io_done, io_err, io_enq_ready});
    else passed++;
    total++;
    if (io_bits !== 8'h00)
      $display("FAIL reset_bits got %h want 00", io_bits);
    else passed++;
    total++;
    if (io_tag !== 8'h00)
      $display("FAIL reset_tag got %h want 00", io_tag);
    else passed++;
  endtask

  task automatic test_single();
    do_reset();
    io_enq_valid = 1'b1;
    io_enq_bits  = 8'h11;
    @(negedge clk);
    total++;
    if (io_valid !== 1'b0)
      $display("FAIL single_nobypass valid=%b want 0", io_valid);
    else passed++;
    next_cycle();
    io_enq_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({io_valid, io_done, io_err} !== 3'b110)
      $display("FAIL single_issue got %b want 110",
               {io_valid, io_done, io_err});
    else passed++;
    total++;
    if (io_bits !== 8'h11)
      $display("FAIL single_bits got %h want 11", io_bits);
    else passed++;
    total++;
    if (io_tag !== 8'h11)
      $display("FAIL single_tag got %h want 11", io_tag);
    else passed++;
    next_cycle();
    @(negedge clk);
    total++;
    if ({io_valid, io_done} !== 2'b00)
      $display("FAIL single_idle got %b want 00",
               {io_valid, io_done});
    else passed++;
    total++;
    if (io_tag !== 8'h11)
      $display("FAIL single_tag_hold got %h want 11", io_tag);
    else passed++;
  endtask

  task automatic test_replay_gaps();
    int cyc[$];
    int dones;
    int done_at;
    int g1;
    int g2;
    logic [W-1:0] dtag;
    do_reset();
    dones = 0;
    done_at = -1;
    dtag = '0;
    for (int c = 0; c < 40 && dones == 0; c++) begin
      io_enq_valid = (c == 0);
      io_enq_bits  = 8'h22;
      io_replay    = (cyc.size() < 2);
      @(negedge clk);
      if (io_valid) cyc.push_back(c);
      if (io_done) begin
        dones++;
        done_at = cyc.size();
        dtag = io_tag;
      end
      next_cycle();
    end
    idle_inputs();
    g1 = cyc.size() > 1 ? cyc[1] - cyc[0] - 1 : -1;
    g2 = cyc.size() > 2 ? cyc[2] - cyc[1] - 1 : -1;
    total++;
    if (g1 != 1) $display("FAIL gap1 got %0d want 1", g1);
    else passed++;
    total++;
    if (g2 != 2) $display("FAIL gap2 got %0d want 2", g2);
    else passed++;
    total++;
    if (done_at != 3)
      $display("FAIL gap_done_issue got %0d want 3", done_at);
    else passed++;
    total++;
    if (dtag !== 8'h22)
      $display("FAIL gap_done_tag got %h want 22", dtag);
    else passed++;
  endtask

  task automatic test_max_retry();
    int cyc[$];
    int dones;
    int errs;
    int err_at;
    int bad;
    int exp_gap;
    logic [W-1:0] etag;
    do_reset();
    dones = 0;
    errs = 0;
    err_at = -1;
    bad = 0;
    etag = '0;
    for (int c = 0; c < 120 && errs == 0; c++) begin
      io_enq_valid = (c == 0);
      io_enq_bits  = 8'h33;
      io_replay    = 1'b1;
      @(negedge clk);
      if (io_valid) cyc.push_back(c);
      if (io_done) dones++;
      if (io_err) begin
        errs++;
        err_at = cyc.size();
        etag = io_tag;
      end
      next_cycle();
    end
    idle_inputs();
    for (int i = 1; i < cyc.size(); i++) begin
      exp_gap = 1 << ((i - 1) < 3 ? (i - 1) : 3);
      if (cyc[i] - cyc[i-1] - 1 != exp_gap) bad++;
    end
    total++;
    if (err_at != MR + 1)
      $display("FAIL maxr_err_issue got %0d want %0d", err_at, MR + 1);
    else passed++;
    total++;
    if (etag !== 8'h33)
      $display("FAIL maxr_tag got %h want 33", etag);
    else passed++;
    total++;
    if (dones != 0)
      $display("FAIL maxr_nodone got %0d want 0", dones);
    else passed++;
    total++;
    if (bad != 0)
      $display("FAIL maxr_gaps got %0d bad want 0", bad);
    else passed++;
  endtask

  task automatic test_full();
    logic [W-1:0] got[$];
    int ready_bad;
    int order_bad;
    int a4_at;
    int first_done;
    do_reset();
    ready_bad = 0;
    order_bad = 0;
    a4_at = -1;
    first_done = -1;
    io_replay = 1'b1;
    for (int k = 0; k < 5; k++) begin
      io_enq_valid = 1'b1;
      io_enq_bits  = 8'(8'hA0 + k);
      @(negedge clk);
      if (io_enq_ready !== (k < 4)) ready_bad++;
      if (io_done || io_err) ready_bad++;
      next_cycle();
    end
    io_replay = 1'b0;
    for (int c = 5; c < 200 && got.size() < 5; c++) begin
      @(negedge clk);
      if (io_enq_valid && io_enq_ready) a4_at = c;
      if (io_done) begin
        got.push_back(io_tag);
        if (first_done < 0) first_done = c;
      end
      next_cycle();
      if (a4_at >= 0) io_enq_valid = 1'b0;
    end
    idle_inputs();
    for (int i = 0; i < got.size(); i++)
      if (got[i] !== 8'(8'hA0 + i)) order_bad++;
    total++;
    if (ready_bad != 0)
      $display("FAIL full_ready got %0d bad want 0", ready_bad);
    else passed++;
    total++;
    if (got.size() != 5 || order_bad != 0)
      $display("FAIL full_order got %0d done %0d bad want 5 0",
               got.size(), order_bad);
    else passed++;
    total++;
    if (first_done < 0 || a4_at <= first_done)
      $display("FAIL full_a4_hold got %0d want > %0d",
               a4_at, first_done);
    else passed++;
  endtask

  task automatic test_stream();
    logic [W-1:0] tags[4];
    logic [W-1:0] got[$];
    int cyc[$];
    int bad;
    int span;
    do_reset();
    bad = 0;
    for (int i = 0; i < 4; i++) tags[i] = 8'($urandom);
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      io_enq_valid = (c < 4);
      if (c < 4) io_enq_bits = tags[c];
      @(negedge clk);
      if (io_valid) cyc.push_back(c);
      if (io_done) got.push_back(io_tag);
      next_cycle();
    end
    idle_inputs();
    for (int i = 0; i < got.size(); i++)
      if (got[i] !== tags[i]) bad++;
    span = cyc.size() == 4 ? cyc[3] - cyc[0] : -1;
    total++;
    if (got.size() != 4 || bad != 0)
      $display("FAIL stream_order got %0d done %0d bad want 4 0",
               got.size(), bad);
    else passed++;
    total++;
    if (span != 3 || cyc[0] != 1)
      $display("FAIL stream_bubbles got span %0d want 3", span);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit fired;
    int pulses;
    int valids;
    int unready;
    do_reset();
    fired = 1'b0;
    pulses = 0;
    valids = 0;
    unready = 0;
    io_replay = 1'b1;
    for (int c = 0; c < 30 && !fired; c++) begin
      io_enq_valid = (c < 3);
      io_enq_bits  = 8'(8'hC0 + c);
      @(negedge clk);
      if (io_valid && c >= 2) fired = 1'b1;
      next_cycle();
    end
    total++;
    if (!fired || io_valid !== 1'b0)
      $display("FAIL rmid_backoff got fired=%b valid=%b want 1 0",
               fired, io_valid);
    else passed++;
    idle_inputs();
    io_replay = 1'b1;
    reset = 1'b0;
    #1;
    total++;
    if ({io_valid, io_done, io_err, io_enq_ready} !== 4'b0001 ||
        io_bits !== 8'h00 || io_tag !== 8'h00)
      $display("FAIL rmid_outputs got %b %h %h want 0001 00 00",
               {io_valid, io_done, io_err, io_enq_ready},
               io_bits, io_tag);
    else passed++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (io_done || io_err || io_valid) pulses++;
    end
    next_cycle();
    reset = 1'b1;
    io_replay = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (io_valid || io_done || io_err) valids++;
      if (!io_enq_ready) unready++;
      next_cycle();
    end
    total++;
    if (pulses != 0)
      $display("FAIL rmid_pulses got %0d want 0", pulses);
    else passed++;
    total++;
    if (valids != 0 || unready != 0)
      $display("FAIL rmid_empty got %0d %0d want 0 0",
               valids, unready);
    else passed++;
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    int gap;
    int retry;
    int pct;
    logic [W-1:0] last;
    logic [W-1:0] tag;
    logic [W-1:0] exp_tag;
    logic en;
    logic rp;
    logic ev;
    logic ed;
    logic ee;
    logic er;
    do_reset();
    gap = 0;
    retry = 0;
    last = '0;
    for (int c = 0; c < 1500; c++) begin
      pct = c < 500 ? 15 : (c < 1000 ? 60 : 95);
      en  = 1'($urandom_range(0, 1));
      rp  = $urandom_range(0, 99) < 32'(pct);
      tag = 8'($urandom);
      io_enq_valid = en;
      io_enq_bits  = tag;
      io_replay    = rp;
      @(negedge clk);
      er = q.size() < D;
      ev = q.size() > 0 && gap == 0;
      ed = ev && !rp;
      ee = ev && rp && retry == MR;
      exp_tag = (ed || ee) ? q[0] : last;
      total++;
      if (io_enq_ready !== er)
        $display("FAIL rnd_ready c=%0d got %b want %b",
                 c, io_enq_ready, er);
      else passed++;
      total++;
      if (io_valid !== ev)
        $display("FAIL rnd_valid c=%0d got %b want %b",
                 c, io_valid, ev);
      else passed++;
      if (ev) begin
        total++;
        if (io_bits !== q[0])
          $display("FAIL rnd_bits c=%0d got %h want %h",
                   c, io_bits, q[0]);
        else passed++;
      end
      total++;
      if ({io_done, io_err} !== {ed, ee})
        $display("FAIL rnd_pulse c=%0d got %b want %b",
                 c, {io_done, io_err}, {ed, ee});
      else passed++;
      total++;
      if (io_tag !== exp_tag)
        $display("FAIL rnd_tag c=%0d got %h want %h",
                 c, io_tag, exp_tag);
      else passed++;
      last = exp_tag;
      if (ed || ee) begin
        void'(q.pop_front());
        retry = 0;
      end else if (ev) begin
        gap = 1 << (retry < 3 ? retry : 3);
        retry++;
      end else if (gap > 0) begin
        gap--;
      end
      if (en && er) q.push_back(tag);
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_replay_gaps();
    test_max_retry();
    test_full();
    test_stream();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/replay_issuer.md
REPLAY_ISSUER -- requirements
Module: replay_issuer

Interface
REQ-001 Parameters: WIDTH, 8, request tag width; DEPTH, 4, pending-request buffer entries (power of 2); MAX_RETRY, 7, replays tolerated before a request is dropped.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 io_enq_valid  input  1  new request offered.
REQ-005 io_enq_ready  output  1  buffer can accept; high when fewer than DEPTH entries are held.
REQ-006 io_enq_bits  input  WIDTH  request tag.
REQ-007 io_valid  output  1  request issued to responders this cycle.
REQ-008 io_bits  output  WIDTH  tag of issued request.
REQ-009 io_replay  input  1  responder demands re-issue; meaningful only while io_valid=1, same cycle (combinational responder).
REQ-010 io_done  output  1  one-cycle pulse: head request accepted (issued without replay).
REQ-011 io_err  output  1  one-cycle pulse: head request dropped after MAX_RETRY replays.
REQ-012 io_tag  output  WIDTH  tag qualified by io_done or io_err.

Function
REQ-013 Enqueue fires when io_enq_valid and io_enq_ready are both 1; the tag is written at the tail of a DEPTH-entry FIFO.
REQ-014 FSM states: IDLE, ISSUE, BACKOFF.
REQ-015 IDLE: io_valid=0; move to ISSUE the cycle after the FIFO becomes non-empty (no enqueue-to-issue bypass; minimum latency 1 cycle).
REQ-016 ISSUE: io_valid=1, io_bits=head tag.
REQ-017 ISSUE with io_replay=0: pop head, pulse io_done with io_tag=head tag, clear retry count; next state ISSUE if FIFO still non-empty after the pop (counting a same-cycle enqueue), else IDLE.
REQ-018 ISSUE with io_replay=1 and retry count < MAX_RETRY: increment retry count (3-bit for default), load backoff counter with 2^min(retry count before increment,3) - 1, enter BACKOFF.
REQ-019 ISSUE with io_replay=1 and retry count = MAX_RETRY: pop head, pulse io_err with io_tag=head tag, clear retry count, next state per REQ-017 rule.
REQ-020 BACKOFF: io_valid=0; decrement counter each cycle; return to ISSUE the cycle after it reads 0 (backoff of 0 → ISSUE next cycle).
REQ-021 io_replay is ignored whenever io_valid=0.
REQ-022 Simultaneous enqueue and pop on a full FIFO: io_enq_ready is 0 when full, so no enqueue that cycle (no pass-through).
REQ-023 Head/tail pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-024 io_done and io_err are never both 1; io_tag holds last reported tag when neither pulses.

Reset
REQ-025 While reset=0: state IDLE, FIFO empty, retry and backoff counters 0; outputs io_valid=0, io_done=0, io_err=0, io_enq_ready=1, io_bits=0, io_tag=0.
REQ-026 Reset mid-operation discards all pending requests without io_done/io_err reporting.
REQ-027 Reset deassertion is synchronised to clk in the integrating parent, not inside this block.

Structure
REQ-028 Shared package holds FSM state encoding (IDLE=0, ISSUE=1, BACKOFF=2) and default WIDTH/DEPTH/MAX_RETRY constants.
REQ-029 The FIFO is one sub-module, replay_fifo (enq/deq, full/empty, head data); FSM and counters stay in replay_issuer.

Verification
REQ-030 Enqueue tag 0x11, io_replay held 0 → io_valid in cycle after enqueue, io_done pulse with io_tag=0x11 same cycle, then IDLE.
REQ-031 Enqueue 0x22, io_replay=1 for first two issues → gaps of 1 and 2 idle cycles between issues, io_done on third issue.
REQ-032 io_replay held 1, tag 0x33 → 8 issues total (backoffs 1,2,4,8,8,8,8 cycles), io_err pulse with io_tag=0x33 on the 8th, no io_done.
REQ-033 Enqueue 0xA0..0xA4 back-to-back with io_replay=1 → io_enq_ready drops after 4th, 0xA4 held until first pop; order preserved.
REQ-034 Stream of 4 tags, io_replay=0 → back-to-back io_valid, four io_done in FIFO order, no bubbles.
REQ-035 Assert reset during BACKOFF with 3 entries queued → outputs per REQ-025 immediately, no pulses, FIFO empty after release.
